// File: rtl/dot_result_buffer.sv
// Small FIFO between the free-running dot product unit and a slower valid/ready consumer.
// Optional running sum of accepted results is enabled with `define RESULT_SUM_EN.
module dot_result_buffer #(
  parameter int DW    = 18,
  parameter int DEPTH = 4,
  parameter int SUM_W = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  output logic [DW-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clear_ovf
`ifdef RESULT_SUM_EN
  ,
  output logic [SUM_W-1:0]       sum_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Zero-extend a result and add it to the running sum, wrapping at SUM_W bits.
  function automatic logic [SUM_W-1:0] sum_wrap_add(input logic [SUM_W-1:0] acc,
                                                     input logic [DW-1:0]    val);
    logic [SUM_W-1:0] ext;
    ext = '0;
    ext[DW-1:0] = val;
    return acc + ext;
  endfunction

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & out_ready;
  assign w_push  = in_valid & (~w_full | w_pop);
  assign w_drop  = in_valid & w_full & ~w_pop;

  // Storage is never reset; only pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      // A drop in the same cycle as clear_ovf keeps the flag set.
      if (w_drop)         r_overflow <= 1'b1;
      else if (clear_ovf) r_overflow <= 1'b0;
    end
  end

`ifdef RESULT_SUM_EN
  logic [SUM_W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset)       r_sum <= '0;
    else if (w_push) r_sum <= sum_wrap_add(r_sum, in_data);
  end

  assign sum_out = r_sum;
`endif

  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_dot_result_buffer.sv
// Randomized scoreboard bench for dot_result_buffer with a queue-based reference model.
module tb_dot_result_buffer;
  localparam int DW    = 18;
  localparam int DEPTH = 4;
  localparam int SUM_W = 24;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [DW-1:0]          in_data = '0;
  logic                   in_valid = 1'b0;
  logic [DW-1:0]          out_data;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   overflow;
  logic                   clear_ovf = 1'b0;
`ifdef RESULT_SUM_EN
  logic [SUM_W-1:0]       sum_out;
`endif

  dot_result_buffer #(.DW(DW), .DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .clear_ovf(clear_ovf)
`ifdef RESULT_SUM_EN
    , .sum_out(sum_out)
`endif
  );

  always #5 clk = ~clk;

  int unsigned     n_cmp = 0;
  int unsigned     n_bad = 0;
  bit              done = 1'b0;
  logic [DW-1:0]   mq[$];
  logic [DW-1:0]   exp_q[$];
  bit              m_ovf = 1'b0;
  longint unsigned m_sum = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, predict from the queue model, advance at the edge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit rdy,
                     input bit clr, input bit rs);
    bit pop, push, drop;
    logic [DW-1:0] tmp;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    clear_ovf = clr;
    reset     = rs;
    pop  = (mq.size() > 0) && rdy;
    push = v && ((mq.size() < DEPTH) || pop);
    drop = v && !push;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_sum = 0;
    end else begin
      if (pop) tmp = mq.pop_front();
      if (push) begin
        mq.push_back(d);
        exp_q.push_back(d);
        m_sum = (m_sum + longint'(d)) % (64'd1 << SUM_W);
      end
      if (drop)     m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    #1;
  endtask

  // Monitor: checks DUT state against the scoreboard and retires popped entries.
  always @(negedge clk) begin
    logic [DW-1:0] tmp;
    if (!done && !reset) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("out_data", 32'(out_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef RESULT_SUM_EN
      chk("sum_out", 32'(sum_out), 32'(m_sum));
`endif
      if (out_valid && out_ready && exp_q.size() > 0) tmp = exp_q.pop_front();
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got running expected finished");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // single result 32, held, then popped
    cyc(1, 32, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // 32 then 140, drained back-to-back
    cyc(1, 32, 0, 0, 0);
    cyc(1, 140, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    // fill, drop, push-while-full with pop, clear, drop+clear
    for (int i = 1; i <= 4; i++) cyc(1, DW'(i), 0, 0, 0);
    cyc(1, 5, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 9, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 7, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    // pointer wrap with occupancy alternating 1 <-> 2
    cyc(1, 100, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, DW'(200 + i), 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
    end
    cyc(0, 0, 1, 0, 0);
    // reset with three entries held
    for (int i = 0; i < 3; i++) cyc(1, DW'(50 + i), 0, 0, 0);
    cyc(1, 77, 1, 0, 1);
    cyc(0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 9) < 6), DW'($urandom), ($urandom_range(0, 9) < 4),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    done = 1'b1;
    if (n_cmp < 12) begin
      n_bad++;
      $display("FAIL cmp_count: got %0d expected at least 12", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
